alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 35 +++
 rtl/alu_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle of every sequencer-facing bus: instruction handshake, register file,
// ALU, flags, address handshake and retire/error pulses.
interface alu_sequencer_if;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  alu_s;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic [15:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        done;
  logic        err;

  modport master (
    input  ir_data, ir_valid, rf_rdata, alu_out, alu_flags, addr_ready,
    output ir_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_s, alu_a, alu_b,
           flags, addr_out, addr_valid, done, err
  );

  modport slave (
    output ir_data, ir_valid, rf_rdata, alu_out, alu_flags, addr_ready,
    input  ir_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_s, alu_a, alu_b,
           flags, addr_out, addr_valid, done, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two registers, drives an external ALU, then
// either writes back (class 11) or issues a load/store address (class 00/01).
module alu_sequencer #(
  parameter logic [3:0] CMP_OP = 4'b0101
) (
  input  logic             clk,
  input  logic             n_rst,
  alu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, READ_A, READ_B, EXEC, WB, ADDR, ILLEGAL
  } state_t;

  state_t      state;
  logic [15:4] ir;
  logic [15:0] ar;
  logic [15:0] br;
  logic [15:0] res;
  logic [3:0]  flags_r;
  logic        ir_ready_r;
  logic [2:0]  rf_raddr_r;
  logic [3:0]  alu_s_r;
  logic        rf_we_r;
  logic        addr_valid_r;
  logic        err_r;
  logic        done_wb_r;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      ir           <= '0;
      ar           <= '0;
      br           <= '0;
      res          <= '0;
      flags_r      <= '0;
      ir_ready_r   <= 1'b1;
      rf_raddr_r   <= '0;
      alu_s_r      <= '0;
      rf_we_r      <= 1'b0;
      addr_valid_r <= 1'b0;
      err_r        <= 1'b0;
      done_wb_r    <= 1'b0;
    end else begin
      rf_we_r   <= 1'b0;
      err_r     <= 1'b0;
      done_wb_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ir_valid) begin
            ir         <= bus.ir_data[15:4];
            ir_ready_r <= 1'b0;
            if (bus.ir_data[15:14] == 2'b10) begin
              state <= ILLEGAL;
              err_r <= 1'b1;
            end else begin
              state      <= READ_A;
              rf_raddr_r <= bus.ir_data[13:11];
              alu_s_r    <= (bus.ir_data[15:14] == 2'b11) ? bus.ir_data[7:4] : 4'b0000;
            end
          end
        end
        READ_A: begin
          ar         <= bus.rf_rdata;
          rf_raddr_r <= ir[10:8];
          state      <= READ_B;
        end
        READ_B: begin
          br    <= bus.rf_rdata;
          state <= EXEC;
        end
        EXEC: begin
          res <= bus.alu_out;
          if (ir[15:14] == 2'b11) begin
            flags_r   <= bus.alu_flags;
            rf_we_r   <= (ir[7:4] != CMP_OP);
            done_wb_r <= 1'b1;
            state     <= WB;
          end else begin
            addr_valid_r <= 1'b1;
            state        <= ADDR;
          end
        end
        WB: begin
          alu_s_r    <= 4'b0000;
          ir_ready_r <= 1'b1;
          state      <= IDLE;
        end
        ADDR: begin
          // Address and valid stay frozen until the memory unit takes them.
          if (bus.addr_ready) begin
            addr_valid_r <= 1'b0;
            alu_s_r      <= 4'b0000;
            ir_ready_r   <= 1'b1;
            state        <= IDLE;
          end
        end
        ILLEGAL: begin
          ir_ready_r <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          addr_valid_r <= 1'b0;
          alu_s_r      <= 4'b0000;
          ir_ready_r   <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Address retirement completes in the handshake cycle itself, so that DONE
  // term follows ADDR_READY combinationally; write-back DONE is registered.
  assign bus.done       = done_wb_r | ((state == ADDR) & addr_valid_r & bus.addr_ready);
  assign bus.ir_ready   = ir_ready_r;
  assign bus.rf_raddr   = rf_raddr_r;
  assign bus.rf_we      = rf_we_r;
  assign bus.rf_waddr   = ir[13:11];
  assign bus.rf_wdata   = res;
  assign bus.alu_s      = alu_s_r;
  assign bus.alu_a      = ar;
  assign bus.alu_b      = br;
  assign bus.flags      = flags_r;
  assign bus.addr_out   = res;
  assign bus.addr_valid = addr_valid_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with an instruction-level reference model,
// a behavioural register file and a combinational ALU.
module tb_alu_sequencer;

  localparam logic [3:0] CMP = 4'b0101;

  logic clk;
  logic n_rst;
  alu_sequencer_if bus();

  alu_sequencer #(.CMP_OP(CMP)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [15:0] rf [8];
  logic [15:0] model_rf [8];
  logic [3:0]  model_flags;
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;

  function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1, 4'd5: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: begin r = {a[14:0], 1'b0}; c = a[15]; end
      4'd7: begin r = {1'b0, a[15:1]}; c = a[0]; end
      default: r = b ^ {op, op, op, op};
    endcase
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  always_comb {bus.alu_flags, bus.alu_out} = alu_f(bus.alu_s, bus.alu_a, bus.alu_b);
  assign bus.rf_rdata = rf[bus.rf_raddr];

  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    model_rf[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic exec_instr(input logic [15:0] ir, input int wait_cyc);
    logic [1:0]  cls;
    logic [2:0]  rd;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_addr;
    logic [19:0] r;
    int          cyc;
    int          vcnt;
    int          we_cnt;
    int          end_cyc;
    bit          fin;
    bit          saw_done;
    bit          saw_err;
    cls = ir[15:14];
    rd  = ir[13:11];
    op  = ir[7:4];
    a = model_rf[rd];
    b = model_rf[ir[10:8]];
    exp_addr = a + b;
    r = alu_f(op, a, b);
    @(negedge clk);
    bus.ir_data    = ir;
    bus.ir_valid   = 1'b1;
    bus.addr_ready = 1'($urandom_range(0, 1));
    #1 chk("ir_ready_idle", bus.ir_ready, 1);
    cyc = 0; vcnt = 0; we_cnt = 0; end_cyc = 0;
    fin = 0; saw_done = 0; saw_err = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.ir_valid = 1'b0;
      bus.ir_data  = 16'($urandom);
      if (bus.addr_valid) begin
        vcnt++;
        bus.addr_ready = (vcnt > wait_cyc);
      end else begin
        bus.addr_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.addr_valid) chk("addr_out", bus.addr_out, exp_addr);
      if (bus.rf_we) begin
        we_cnt++;
        chk("rf_waddr", bus.rf_waddr, rd);
        chk("rf_wdata", bus.rf_wdata, r[15:0]);
      end
      if (bus.done || bus.err) begin
        fin = 1; end_cyc = cyc; saw_done = bus.done; saw_err = bus.err;
      end else begin
        chk("ir_ready_busy", bus.ir_ready, 0);
      end
    end
    chk("retired", fin, 1);
    if (cls == 2'b11) begin
      if (op != CMP) model_rf[rd] = r[15:0];
      model_flags = r[19:16];
      chk("latency_alu", end_cyc, 4);
      chk("done_alu", saw_done, 1);
      chk("err_alu", saw_err, 0);
      chk("we_count", we_cnt, (op != CMP) ? 1 : 0);
    end else if (cls == 2'b10) begin
      chk("latency_err", end_cyc, 1);
      chk("err_ill", saw_err, 1);
      chk("done_ill", saw_done, 0);
      chk("we_ill", we_cnt, 0);
      chk("addr_ill", vcnt, 0);
    end else begin
      chk("latency_mem", end_cyc, 4 + wait_cyc);
      chk("addr_valid_cycles", vcnt, wait_cyc + 1);
      chk("done_mem", saw_done, 1);
      chk("we_mem", we_cnt, 0);
    end
    @(negedge clk);
    bus.addr_ready = 1'b0;
    #1;
    chk("ir_ready_after", bus.ir_ready, 1);
    chk("done_after", bus.done, 0);
    chk("err_after", bus.err, 0);
    chk("rf_we_after", bus.rf_we, 0);
    chk("addr_valid_after", bus.addr_valid, 0);
    chk("alu_s_idle", bus.alu_s, 0);
    chk("flags", bus.flags, model_flags);
    chk("rf_rd", rf[rd], model_rf[rd]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ir_ready", bus.ir_ready, 1);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_addr_valid", bus.addr_valid, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_s", bus.alu_s, 0);
  endtask

  task automatic reset_mid(input logic [15:0] ir, input int at_cyc);
    @(negedge clk);
    bus.ir_data    = ir;
    bus.ir_valid   = 1'b1;
    bus.addr_ready = 1'b0;
    for (int i = 0; i < at_cyc; i++) begin
      @(negedge clk);
      bus.ir_valid = 1'b0;
    end
    n_rst = 1'b0;
    @(negedge clk);
    #1 check_reset_outputs();
    n_rst = 1'b1;
    model_flags = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.addr_ready = 1'b1;
      #1;
      check_reset_outputs();
    end
    bus.addr_ready = 1'b0;
    chk("rst_rf_kept", rf[ir[13:11]], model_rf[ir[13:11]]);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_flags = 4'h0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.ir_data = '0;
    bus.ir_valid = 1'b0;
    bus.addr_ready = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    n_rst = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs();

    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));

    set_reg(3'd1, 16'd5);
    set_reg(3'd2, 16'd3);
    exec_instr(16'hCA00, 0);
    chk("dir_add_r1", rf[1], 16'd8);

    set_reg(3'd1, 16'd5);
    exec_instr(16'hCA50, 0);
    chk("dir_cmp_r1", rf[1], 16'd5);

    set_reg(3'd1, 16'h1000);
    set_reg(3'd2, 16'h0004);
    exec_instr(16'h0A00, 3);

    exec_instr(16'h8000, 0);

    reset_mid(16'hCA00, 2);
    reset_mid(16'h0A00, 5);

    // Back-to-back: IR_VALID held high, one accept per 5-cycle instruction.
    set_reg(3'd3, 16'h1234);
    set_reg(3'd4, 16'h0101);
    @(negedge clk);
    bus.ir_data  = 16'hDC00;
    bus.ir_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("b2b_ir_ready", bus.ir_ready, (i % 5 == 0) ? 1 : 0);
      chk("b2b_done", bus.done, (i % 5 == 4) ? 1 : 0);
      @(negedge clk);
    end
    bus.ir_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [19:0] rr;
      rr = alu_f(4'd0, model_rf[3], model_rf[4]);
      model_rf[3] = rr[15:0];
      model_flags = rr[19:16];
    end
    @(negedge clk);
    #1;
    chk("b2b_r3", rf[3], model_rf[3]);
    chk("b2b_flags", bus.flags, model_flags);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) set_reg(3'($urandom), 16'($urandom));
      exec_instr(16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
